// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: instruction decode, NZCV flag register and
// the Moore main FSM that steps the shared memory/ALU datapath.
//
// state  | meaning
// FETCH  | read instruction at PC into IR, PC <= PC+4
// DECODE | read register file, precompute PC+8
// MEMADR | ALU forms load/store address base+imm
// MEMRD  | read data memory at ALUOut
// MEMWB  | write loaded data to Rd
// MEMWR  | write RD2 to data memory at ALUOut
// EXECR  | data-processing op, register operand
// EXECI  | data-processing op, immediate operand
// ALUWB  | write ALU result to Rd (PC when Rd=15)
// BRANCH | PC <= PC+8+imm when condition holds
module arm_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXECR  = 4'd6;
  localparam logic [3:0] EXECI  = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;

  logic [3:0] state, state_nxt, out_state;
  logic [3:0] flags;
  logic [1:0] alu_dec;
  logic       no_write, cmd_ok, arith;
  logic       cond_ex, flag_we;
  logic       pc_w, mem_w, reg_w, ir_w;
  logic       flag_n, flag_z, flag_c, flag_v;

  assign {flag_n, flag_z, flag_c, flag_v} = flags;

  always_comb begin
    alu_dec  = 2'b00;
    no_write = 1'b0;
    cmd_ok   = 1'b1;
    arith    = 1'b0;
    case (Funct[4:1])
      4'b0100: begin alu_dec = 2'b00; arith = 1'b1; end
      4'b0010: begin alu_dec = 2'b01; arith = 1'b1; end
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      4'b1010: begin alu_dec = 2'b01; arith = 1'b1; no_write = 1'b1; end
      default: begin no_write = 1'b1; cmd_ok = 1'b0; end
    endcase
  end

  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   state_nxt = MEMADR;
          2'b00:   state_nxt = Funct[5] ? EXECI : EXECR;
          2'b10:   state_nxt = BRANCH;
          default: state_nxt = FETCH;
        endcase
      end
      MEMADR: state_nxt = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_nxt = MEMWB;
      EXECR:  state_nxt = ALUWB;
      EXECI:  state_nxt = ALUWB;
      default: state_nxt = FETCH;
    endcase
  end

  // Flags capture the ALU result of the execute cycle; condition uses the old flags.
  assign flag_we = ((state == EXECR) || (state == EXECI)) & Funct[0] & cond_ex & cmd_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      flags <= 4'b0000;
    end else begin
      state <= state_nxt;
      if (flag_we) begin
        flags[3:2] <= ALUFlags[3:2];
        if (arith) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // While in reset the selects show FETCH values and every enable is masked.
  assign out_state = reset ? FETCH : state;

  always_comb begin
    pc_w       = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    ir_w       = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (out_state)
      FETCH: begin
        ir_w = 1'b1; pc_w = 1'b1;
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01; reg_w = cond_ex;
      end
      MEMWR: begin
        AdrSrc = 1'b1; mem_w = cond_ex;
      end
      EXECR: ALUControl = alu_dec;
      EXECI: begin
        ALUSrcB = 2'b01; ALUControl = alu_dec;
      end
      ALUWB: begin
        reg_w = cond_ex & ~no_write;
        pc_w  = cond_ex & ~no_write & (Rd == 4'd15);
      end
      BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; pc_w = cond_ex;
      end
      default: ;
    endcase
  end

  assign PCWrite  = ~reset & pc_w;
  assign MemWrite = ~reset & mem_w;
  assign RegWrite = ~reset & reg_w;
  assign IRWrite  = ~reset & ir_w;

  assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};
  assign ImmSrc = Op;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Directed bench for arm_multicycle_ctrl: a per-cycle vector table walking a
// program of instructions, then latency and mid-instruction reset sequences.
module tb_arm_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0] RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  arm_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [3:0]  aluf;
    logic [16:0] exp;
    logic [3:0]  fl;
  } vec_t;

  vec_t tbl[$];
  int compared = 0;
  int mismatched = 0;
  logic [3:0] c_cond, c_rd, c_aluf;
  logic [1:0] c_op;
  logic [5:0] c_funct;

  wire [16:0] act = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                     ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

  // Expected output word in port order: enables, AdrSrc, then 2-bit selects.
  function automatic logic [16:0] ev(input logic pcw, mw, rw, irw, adr,
                                     input logic [1:0] rs, sa, sb, res, imm, ac);
    return {pcw, mw, rw, irw, adr, rs, sa, sb, res, imm, ac};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic instr(input logic [3:0] cond, input logic [1:0] op,
                       input logic [5:0] funct, input logic [3:0] rd, input logic [3:0] aluf);
    c_cond = cond; c_op = op; c_funct = funct; c_rd = rd; c_aluf = aluf;
  endtask

  task automatic row(input logic rst, input logic [16:0] exp, input logic [3:0] fl);
    vec_t v;
    v.rst = rst; v.cond = c_cond; v.op = c_op; v.funct = c_funct;
    v.rd = c_rd; v.aluf = c_aluf; v.exp = exp; v.fl = fl;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [3:0] cond, input logic [1:0] op,
                       input logic [5:0] funct, input logic [3:0] rd);
    Cond = cond; Op = op; Funct = funct; Rd = rd; ALUFlags = 4'b0000;
  endtask

  // Starts in a FETCH cycle; counts cycles until the next FETCH.
  task automatic latency(input string name, input logic [1:0] op,
                         input logic [5:0] funct, input int want);
    int n;
    drive(4'b1110, op, funct, 4'd1);
    @(posedge clk); #1;
    n = 1;
    while (!IRWrite && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, n, want);
  endtask

  initial begin
    reset = 1'b1;
    drive(4'b1110, 2'b00, 6'b001000, 4'd1);

    // Reset, then ADD R1,R2,R3
    instr(4'b1110, 2'b00, 6'b001000, 4'd1, 4'b0000);
    row(1, ev(0,0,0,0,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b0000);
    row(1, ev(0,0,0,0,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b0000);
    row(0, ev(1,0,0,1,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b0000);
    row(0, ev(0,0,0,0,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b0000);
    row(0, ev(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 4'b0000);
    row(0, ev(0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 4'b0000);
    // LDR: ALUControl stays 00 although cmd bits look like ORR
    instr(4'b1110, 2'b01, 6'b011001, 4'd4, 4'b0000);
    row(0, ev(1,0,0,1,0, 2'b10,2'b01,2'b10,2'b10,2'b01,2'b00), 4'b0000);
    row(0, ev(0,0,0,0,0, 2'b10,2'b01,2'b10,2'b10,2'b01,2'b00), 4'b0000);
    row(0, ev(0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00,2'b01,2'b00), 4'b0000);
    row(0, ev(0,0,0,0,1, 2'b10,2'b00,2'b00,2'b00,2'b01,2'b00), 4'b0000);
    row(0, ev(0,0,1,0,0, 2'b10,2'b00,2'b00,2'b01,2'b01,2'b00), 4'b0000);
    // STR
    instr(4'b1110, 2'b01, 6'b011000, 4'd5, 4'b0000);
    row(0, ev(1,0,0,1,0, 2'b10,2'b01,2'b10,2'b10,2'b01,2'b00), 4'b0000);
    row(0, ev(0,0,0,0,0, 2'b10,2'b01,2'b10,2'b10,2'b01,2'b00), 4'b0000);
    row(0, ev(0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00,2'b01,2'b00), 4'b0000);
    row(0, ev(0,1,0,0,1, 2'b10,2'b00,2'b00,2'b00,2'b01,2'b00), 4'b0000);
    // CMP with Z result
    instr(4'b1110, 2'b00, 6'b010101, 4'd1, 4'b0100);
    row(0, ev(1,0,0,1,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b0000);
    row(0, ev(0,0,0,0,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b0000);
    row(0, ev(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b01), 4'b0000);
    row(0, ev(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 4'b0100);
    // BEQ taken
    instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000);
    row(0, ev(1,0,0,1,0, 2'b01,2'b01,2'b10,2'b10,2'b10,2'b00), 4'b0100);
    row(0, ev(0,0,0,0,0, 2'b01,2'b01,2'b10,2'b10,2'b10,2'b00), 4'b0100);
    row(0, ev(1,0,0,0,0, 2'b01,2'b00,2'b01,2'b10,2'b10,2'b00), 4'b0100);
    // CMP with nonzero result
    instr(4'b1110, 2'b00, 6'b010101, 4'd1, 4'b0000);
    row(0, ev(1,0,0,1,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b0100);
    row(0, ev(0,0,0,0,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b0100);
    row(0, ev(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b01), 4'b0100);
    row(0, ev(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 4'b0000);
    // BEQ not taken
    instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000);
    row(0, ev(1,0,0,1,0, 2'b01,2'b01,2'b10,2'b10,2'b10,2'b00), 4'b0000);
    row(0, ev(0,0,0,0,0, 2'b01,2'b01,2'b10,2'b10,2'b10,2'b00), 4'b0000);
    row(0, ev(0,0,0,0,0, 2'b01,2'b00,2'b01,2'b10,2'b10,2'b00), 4'b0000);
    // ADDS sets C,V
    instr(4'b1110, 2'b00, 6'b001001, 4'd2, 4'b0011);
    row(0, ev(1,0,0,1,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b0000);
    row(0, ev(0,0,0,0,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b0000);
    row(0, ev(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 4'b0000);
    row(0, ev(0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 4'b0011);
    // ORRS holds C,V
    instr(4'b1110, 2'b00, 6'b011001, 4'd3, 4'b1000);
    row(0, ev(1,0,0,1,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b0011);
    row(0, ev(0,0,0,0,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b0011);
    row(0, ev(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b11), 4'b0011);
    row(0, ev(0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 4'b1011);
    // ADD immediate to R15
    instr(4'b1110, 2'b00, 6'b101000, 4'd15, 4'b0000);
    row(0, ev(1,0,0,1,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b1011);
    row(0, ev(0,0,0,0,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b1011);
    row(0, ev(0,0,0,0,0, 2'b00,2'b00,2'b01,2'b00,2'b00,2'b00), 4'b1011);
    row(0, ev(1,0,1,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 4'b1011);
    // ADDEQ to R15 with Z=0: all writes suppressed
    instr(4'b0000, 2'b00, 6'b001000, 4'd15, 4'b0000);
    row(0, ev(1,0,0,1,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b1011);
    row(0, ev(0,0,0,0,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b1011);
    row(0, ev(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 4'b1011);
    row(0, ev(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 4'b1011);
    // unsupported cmd with S: no write, no flag update
    instr(4'b1110, 2'b00, 6'b000011, 4'd6, 4'b0101);
    row(0, ev(1,0,0,1,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b1011);
    row(0, ev(0,0,0,0,0, 2'b00,2'b01,2'b10,2'b10,2'b00,2'b00), 4'b1011);
    row(0, ev(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 4'b1011);
    row(0, ev(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00,2'b00), 4'b1011);
    // undefined op
    instr(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000);
    row(0, ev(1,0,0,1,0, 2'b00,2'b01,2'b10,2'b10,2'b11,2'b00), 4'b1011);
    row(0, ev(0,0,0,0,0, 2'b00,2'b01,2'b10,2'b10,2'b11,2'b00), 4'b1011);
    // STREQ failing
    instr(4'b0000, 2'b01, 6'b011000, 4'd5, 4'b0000);
    row(0, ev(1,0,0,1,0, 2'b10,2'b01,2'b10,2'b10,2'b01,2'b00), 4'b1011);
    row(0, ev(0,0,0,0,0, 2'b10,2'b01,2'b10,2'b10,2'b01,2'b00), 4'b1011);
    row(0, ev(0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00,2'b01,2'b00), 4'b1011);
    row(0, ev(0,0,0,0,1, 2'b10,2'b00,2'b00,2'b00,2'b01,2'b00), 4'b1011);

    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      reset = tbl[i].rst; Cond = tbl[i].cond; Op = tbl[i].op;
      Funct = tbl[i].funct; Rd = tbl[i].rd; ALUFlags = tbl[i].aluf;
      @(negedge clk);
      chk($sformatf("row%0d outputs", i), {15'd0, act}, {15'd0, tbl[i].exp});
      chk($sformatf("row%0d flags", i), {28'd0, dut.flags}, {28'd0, tbl[i].fl});
      @(posedge clk); #1;
    end

    latency("lat_dp", 2'b00, 6'b001000, 4);
    latency("lat_ldr", 2'b01, 6'b011001, 5);
    latency("lat_str", 2'b01, 6'b011000, 4);
    latency("lat_b", 2'b10, 6'b100000, 3);
    latency("lat_undef", 2'b11, 6'b000000, 2);

    // LDR aborted by reset in MEMWB
    drive(4'b1110, 2'b01, 6'b011001, 4'd4);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("abort_memrd_adrsrc", {31'd0, AdrSrc}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rst1_outputs", {15'd0, act},
        {15'd0, ev(0,0,0,0,0, 2'b10,2'b01,2'b10,2'b10,2'b01,2'b00)});
    @(posedge clk); #1;
    chk("abort_rst_flags", {28'd0, dut.flags}, 32'd0);
    @(negedge clk);
    chk("abort_rst2_outputs", {15'd0, act},
        {15'd0, ev(0,0,0,0,0, 2'b10,2'b01,2'b10,2'b10,2'b01,2'b00)});
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_fetch", {30'd0, PCWrite, IRWrite}, 32'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_decode", {30'd0, PCWrite, IRWrite}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
